// File: rtl/compuerta_and_or_pipe.sv
// Pipelined, mask-programmable two-level gate (AND-OR / OR-AND / parity).
// Fixed 2-cycle latency, full throughput, saturating count of high results.
module compuerta_and_or_pipe #(
    parameter int WIDTH  = 3,
    parameter int TERMS  = 2,
    parameter int INVERT = 0,
    parameter int CNT_W  = 16,
    localparam int CFG_W = (TERMS > 1) ? $clog2(TERMS) : 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    input  logic [WIDTH-1:0] iA,
    input  logic [1:0]       iMode,
    input  logic             iCfgWe,
    input  logic [CFG_W-1:0] iCfgTerm,
    input  logic [WIDTH-1:0] iCfgMask,
    input  logic             iClrCnt,
    output logic             oValid,
    output logic             oSalida,
    output logic [TERMS-1:0] oTerms,
    output logic [CNT_W-1:0] oCount
);

    localparam logic [WIDTH-1:0] MASK_LO  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MASK_HI  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CFG_W:0]   TERMS_L  = (CFG_W+1)'(TERMS);
    localparam logic             INV_BIT  = (INVERT != 0);

    logic [WIDTH-1:0] mask_q [TERMS];

    logic             s1_valid_q;
    logic [1:0]       s1_mode_q;
    logic [TERMS-1:0] s1_terms_q;
    logic [TERMS-1:0] terms_d;

    logic             s2_valid_q;
    logic             s2_out_q;
    logic [TERMS-1:0] s2_terms_q;
    logic             result_d;

    logic [CNT_W-1:0] cnt_q;

    // Reset default for each term mask: low bits in term 0, MSB in term 1.
    function automatic logic [WIDTH-1:0] mask_dflt(input int k);
        if (TERMS == 1) return '1;
        if (k == 0) return MASK_LO;
        if (k == 1) return MASK_HI;
        return '0;
    endfunction

    // Term mask storage; out-of-range term indices are dropped.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int k = 0; k < TERMS; k++) begin
                mask_q[k] <= mask_dflt(k);
            end
        end else if (iCfgWe && ({1'b0, iCfgTerm} < TERMS_L)) begin
            mask_q[iCfgTerm] <= iCfgMask;
        end
    end

    // Per-term evaluation of the incoming sample against the current masks.
    always_comb begin
        terms_d = '0;
        for (int k = 0; k < TERMS; k++) begin
            case (iMode)
                2'b00: terms_d[k] = (mask_q[k] != '0) &&
                                    (&(iA | ~mask_q[k]));
                2'b01: terms_d[k] = (mask_q[k] == '0) ||
                                    (|(iA & mask_q[k]));
                2'b10: terms_d[k] = (k == 0) ? ^(iA & mask_q[0]) : 1'b0;
                default: terms_d[k] = 1'b0;
            endcase
        end
    end

    // Stage 1: capture terms and mode of each accepted sample.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 2'b00;
            s1_terms_q <= '0;
        end else begin
            s1_valid_q <= iValid;
            if (iValid) begin
                s1_mode_q  <= iMode;
                s1_terms_q <= terms_d;
            end
        end
    end

    // Second-level combine of the stage-1 terms, then optional inversion.
    always_comb begin
        result_d = 1'b0;
        case (s1_mode_q)
            2'b00:   result_d = |s1_terms_q;
            2'b01:   result_d = &s1_terms_q;
            2'b10:   result_d = s1_terms_q[0];
            default: result_d = 1'b0;
        endcase
        result_d = result_d ^ INV_BIT;
    end

    // Stage 2: register result; data holds while no sample arrives.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            s2_valid_q <= 1'b0;
            s2_out_q   <= 1'b0;
            s2_terms_q <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_out_q   <= result_d;
                s2_terms_q <= s1_terms_q;
            end
        end
    end

    // Saturating count of high results; clear wins over increment.
    always_ff @(posedge iClk) begin
        if (iRst || iClrCnt) begin
            cnt_q <= '0;
        end else if (s1_valid_q && result_d && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign oValid  = s2_valid_q;
    assign oSalida = s2_out_q;
    assign oTerms  = s2_terms_q;
    assign oCount  = cnt_q;

endmodule

// File: doc/compuerta_and_or_pipe.md
Name: compuerta_and_or_pipe

Overview:
- Parametrised, pipelined sum-of-products gate: next generation of the registered two-level AND→OR gate.
- Generalised to WIDTH inputs and TERMS product terms, with per-term runtime-programmable input masks.
- Per-sample mode selects AND-OR, OR-AND or masked parity.
- Adds valid propagation and a saturating counter of high results; used wherever the datapath needs programmable two-level logic with fixed latency.

Parameters:
- WIDTH, 3, input vector width; legal range 2..32.
- TERMS, 2, number of product/sum terms; legal range 1..8.
- INVERT, 0, 1 inverts the final result before the output register.
- CNT_W, 16, width of the high-result counter.

Ports:
- iClk  in  1  clock; all state updates on rising edge.
- iRst  in  1  synchronous active-high reset.
- iValid  in  1  iA/iMode carry a sample this cycle.
- iA  in  WIDTH  input operand.
- iMode  in  2  per-sample mode: 00 AND-OR, 01 OR-AND, 10 parity, 11 reserved.
- iCfgWe  in  1  mask write strobe.
- iCfgTerm  in  max(1,clog2(TERMS))  index of the term mask to write.
- iCfgMask  in  WIDTH  new mask value.
- iClrCnt  in  1  clear oCount.
- oValid  out  1  oSalida/oTerms valid; high exactly 2 cycles after the accepted iValid.
- oSalida  out  1  registered result.
- oTerms  out  TERMS  registered per-term values of the same sample, for debug.
- oCount  out  CNT_W  number of valid results with oSalida=1, saturating.

Behaviour:
- Reset (iRst=1 at edge) sets oValid, oSalida, oTerms and oCount to 0 and clears both pipeline valid bits; in-flight samples are dropped.
- Reset restores mask defaults:
  - TERMS=1: mask0 = all ones.
  - TERMS≥2: mask0 = bits WIDTH-2..0, mask1 = bit WIDTH-1, others 0.
  - With defaults, WIDTH=3 and mode 00, the gate computes (iA[1]&iA[0])|iA[2].
- A term is active iff its mask ≠ 0.
- Stage 1, captured when iValid=1: term_k and the mode are registered.
  - Mode 00: term_k = AND of iA bits selected by mask_k; inactive term = 0.
  - Mode 01: term_k = OR of selected bits; inactive term = 1.
  - Mode 10: term_0 = XOR of iA & mask0; other terms = 0.
  - Mode 11: all terms = 0.
- Stage 2: result is registered into oSalida and oTerms, with oValid=1.
  - Mode 00: result = OR of terms (0 if no active term).
  - Mode 01: result = AND of terms (1 if no active term).
  - Mode 10: result = term_0.
  - Mode 11: result = 0.
  - INVERT=1 inverts the result in all modes, including 11.
- Latency is fixed at 2 cycles. Full throughput: one sample per cycle, no stall, no backpressure.
- When oValid=0, oSalida and oTerms hold their last value.
- Config writes:
  - Mask takes effect for samples with iValid in the cycle after iCfgWe.
  - A sample accepted in the same cycle as the write uses the old mask.
  - Samples already in stage 1 are unaffected.
  - iCfgTerm ≥ TERMS: write ignored.
- oCount increments on each stage-2 output with result=1 and saturates at 2^CNT_W-1.
  - iClrCnt has priority over increment: the counter reads 0 next cycle even if an increment coincides.
- Masks are not cleared by iClrCnt; only iRst restores them.

Test Plan:
- Reset, WIDTH=3, mode 00, stream iA=0..7 on consecutive cycles → oValid asserted cycles 2..9; oSalida sequence 0,0,0,1,1,1,1,1; oCount=5.
- Write mask0=3'b111 with iCfgWe in the same cycle as iA=3'b011 valid, then iA=3'b011 next cycle → first result 1 (old mask), second result 0.
- Mode 01 with defaults, iA=3'b101 → terms (1,1), oSalida=1; iA=3'b100 → terms (0,1), oSalida=0. Clear all masks, mode 01 → 1; mode 00 → 0.
- Mode 10, mask0=3'b111, iA=3'b110 → 0; iA=3'b111 → 1. Mode 11 with INVERT=1 → oSalida=1.
- CNT_W=2, five high results → oCount stops at 3; iClrCnt coinciding with a high result → oCount=0.
- Assert iRst while two samples are in flight → oValid never rises for them; oCount=0; masks back to defaults.
